hash_match_stage: RTL and testbench
===================================

HASH_MATCH_STAGE -- requirements
Module: hash_match_stage

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, meaning bucket slots per row.
REQ-002 SHALL have parameter NUM_WR, default 8, meaning XOR banks per slot.
REQ-003 SHALL have parameter INDEX_WIDTH, default 12, meaning row index width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, meaning entry width.
REQ-005 SHALL have parameter KEY_WIDTH, default 32, meaning key width; VW = DATA_WIDTH-1-KEY_WIDTH.
REQ-006 SHALL have port clk, in, 1, the single clock.
REQ-007 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-008 SHALL have port rd_out_all_update, in, NUM_MUL*NUM_WR*DATA_WIDTH, DFU-updated bank words from the row stage.
REQ-009 SHALL have ports rd_key_in (in, KEY_WIDTH), rd_opt_in (in, 2), rd_index_in (in, INDEX_WIDTH), rd_value_in (in, VW), all aligned with rd_out_all_update.
REQ-010 SHALL have result outputs res_valid (1), res_opt (2), res_key (KEY_WIDTH), res_hit (1), res_value (VW), res_slot (clog2(NUM_MUL)).
REQ-011 SHALL have write-request outputs wr_valid (1), wr_index (INDEX_WIDTH), wr_slot (clog2(NUM_MUL)), wr_data (DATA_WIDTH).
REQ-012 SHALL have counter outputs hit_cnt (16) and ins_fail_cnt (16).

Function
REQ-013 SHALL decode opcodes as 0 = idle, 1 = search, 2 = insert, 3 = delete.
REQ-014 SHALL use entry format: bit DATA_WIDTH-1 = valid; [DATA_WIDTH-2:KEY_WIDTH] = value; [KEY_WIDTH-1:0] = key.
REQ-015 SHALL decode slot m as the XOR over w of rd_out_all_update[(w*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have stage A register the decoded entries, the match vector (valid AND key equal), the free vector (valid = 0), opt, key, index and value.
REQ-017 SHALL have stage B priority-encode (lowest slot wins) and register all outputs; total latency is 2 cycles from input to res_valid.
REQ-018 SHALL drive res_valid = 1 iff the stage-B opt != 0; res_opt and res_key echo the input.
REQ-019 For search, SHALL output res_hit = any match, res_value = matched value (0 if miss) and res_slot = lowest matching slot; wr_valid = 0.
REQ-020 For insert with a match, SHALL issue wr_valid = 1 to the matched slot with wr_data = {1, rd_value, key}; res_hit = 1.
REQ-021 For insert with no match, SHALL write the lowest free slot with res_hit = 0.
REQ-022 For insert with no match and no free slot, SHALL set wr_valid = 0 and increment ins_fail_cnt.
REQ-023 For delete with a match, SHALL issue a write of all-zero data to the lowest matching slot with res_hit = 1; a delete miss issues no write.
REQ-024 For idle, SHALL set wr_valid = 0, res_valid = 0 and leave the counters unchanged.
REQ-025 SHALL increment hit_cnt on every res_valid with res_hit = 1; both counters saturate at 16'hFFFF.
REQ-026 (forwarding) If wr_valid is issued in cycle t and the operation entering stage A in cycle t has the same rd_index_in, stage A SHALL replace decoded slot wr_slot with wr_data before computing match and free vectors.
REQ-027 Duplicate matching slots SHALL resolve to the lowest slot index only.
REQ-028 wr_index SHALL equal the index of the operation that produced the write.

Reset
REQ-029 Asserting reset (low) SHALL immediately clear res_valid, wr_valid, res_hit, hit_cnt, ins_fail_cnt, all stage-valid and opt registers, and the forwarding state.
REQ-030 Operations in flight at reset SHALL be discarded; no write is issued in the first 2 cycles after release unless a new op enters.
REQ-031 Data/key/value pipeline registers need not be reset.

Verification
REQ-032 Search key 0x1234 present in slot 2 with value 7, encoded as bank 0 = entry and other banks = 0 -> 2 cycles later: res_hit = 1, res_slot = 2, res_value = 7, wr_valid = 0, hit_cnt += 1.
REQ-033 Insert key 0xAB value 5 into a row with slots 0 and 1 valid and slot 2 free -> wr_valid = 1, wr_slot = 2, wr_data = {1, 5, 0xAB}, res_hit = 0.
REQ-034 Insert into a full row with no match -> wr_valid = 0 and ins_fail_cnt increments; with ins_fail_cnt preset by 65535 fails, it holds 0xFFFF.
REQ-035 Back-to-back insert key 0x10 then search key 0x10 on the same index, where memory shows the row empty -> search returns res_hit = 1 via forwarding.
REQ-036 Delete key 0x55 present in slots 1 and 3 -> wr_slot = 1, wr_data = 0, res_hit = 1; delete of an absent key -> wr_valid = 0.
REQ-037 Assert reset while an insert is in stage A -> outputs are 0 immediately; after release, no wr_valid appears for that op.

Source files
------------

// File: rtl/hash_match_stage.sv
// Two-stage hash bucket match: decode/compare a row of XOR-banked slots,
// then pick the winning slot and emit the result plus any row write-back.
`timescale 1ns/1ps
module hash_match_stage #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int KEY_WIDTH   = 32,
  localparam int VW = DATA_WIDTH - 1 - KEY_WIDTH,
  localparam int SW = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0] rd_out_all_update,
  input  logic [KEY_WIDTH-1:0]               rd_key_in,
  input  logic [1:0]                         rd_opt_in,
  input  logic [INDEX_WIDTH-1:0]             rd_index_in,
  input  logic [VW-1:0]                      rd_value_in,
  output logic                               res_valid,
  output logic [1:0]                         res_opt,
  output logic [KEY_WIDTH-1:0]               res_key,
  output logic                               res_hit,
  output logic [VW-1:0]                      res_value,
  output logic [SW-1:0]                      res_slot,
  output logic                               wr_valid,
  output logic [INDEX_WIDTH-1:0]             wr_index,
  output logic [SW-1:0]                      wr_slot,
  output logic [DATA_WIDTH-1:0]              wr_data,
  output logic [15:0]                        hit_cnt,
  output logic [15:0]                        ins_fail_cnt
);

  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_SEARCH = 2'd1, OP_INSERT = 2'd2, OP_DELETE = 2'd3} op_e;

  // stage A
  logic [NUM_MUL-1:0][DATA_WIDTH-1:0] dec;
  logic [NUM_MUL-1:0]                 match_d, free_d, a_match_q, a_free_q;
  logic [NUM_MUL-1:0][VW-1:0]         vals_d, a_vals_q;
  op_e                                a_opt_q;
  logic [KEY_WIDTH-1:0]               a_key_q;
  logic [INDEX_WIDTH-1:0]             a_index_q;
  logic [VW-1:0]                      a_value_q;

  // stage B
  logic                   any_match, any_free, ins_fail;
  logic [SW-1:0]          msl, fsl;
  logic                   res_valid_d, res_valid_q, res_hit_d, res_hit_q;
  logic [1:0]             res_opt_d, res_opt_q;
  logic [KEY_WIDTH-1:0]   res_key_d, res_key_q;
  logic [VW-1:0]          res_value_d, res_value_q;
  logic [SW-1:0]          res_slot_d, res_slot_q;
  logic                   wr_valid_d, wr_valid_q;
  logic [INDEX_WIDTH-1:0] wr_index_d, wr_index_q;
  logic [SW-1:0]          wr_slot_d, wr_slot_q;
  logic [DATA_WIDTH-1:0]  wr_data_d, wr_data_q;
  logic [15:0]            hit_cnt_d, hit_cnt_q, ins_fail_cnt_d, ins_fail_cnt_q;

  // Memory has not yet absorbed the last two writes, so overlay them:
  // the issued write (older) first, then the one stage B is forming now.
  always_comb begin
    for (int m = 0; m < NUM_MUL; m++) begin
      dec[m] = '0;
      for (int w = 0; w < NUM_WR; w++)
        dec[m] = dec[m] ^ rd_out_all_update[(w*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (wr_valid_q && wr_index_q == rd_index_in) dec[wr_slot_q] = wr_data_q;
    if (wr_valid_d && wr_index_d == rd_index_in) dec[wr_slot_d] = wr_data_d;
    for (int m = 0; m < NUM_MUL; m++) begin
      match_d[m] = dec[m][DATA_WIDTH-1] && (dec[m][KEY_WIDTH-1:0] == rd_key_in);
      free_d[m]  = !dec[m][DATA_WIDTH-1];
      vals_d[m]  = dec[m][DATA_WIDTH-2:KEY_WIDTH];
    end
  end

  always_comb begin
    any_match = |a_match_q;
    any_free  = |a_free_q;
    msl = '0;
    fsl = '0;
    for (int m = NUM_MUL-1; m >= 0; m--) begin
      if (a_match_q[m]) msl = SW'(m);
      if (a_free_q[m])  fsl = SW'(m);
    end
    res_valid_d = (a_opt_q != OP_IDLE);
    res_opt_d   = a_opt_q;
    res_key_d   = a_key_q;
    res_hit_d   = res_valid_d && any_match;
    res_value_d = res_hit_d ? a_vals_q[msl] : '0;
    res_slot_d  = res_hit_d ? msl : '0;
    wr_valid_d  = 1'b0;
    wr_index_d  = a_index_q;
    wr_slot_d   = '0;
    wr_data_d   = '0;
    ins_fail    = 1'b0;
    case (a_opt_q)
      OP_INSERT: begin
        if (any_match) begin
          wr_valid_d = 1'b1;
          wr_slot_d  = msl;
          wr_data_d  = {1'b1, a_value_q, a_key_q};
        end else if (any_free) begin
          wr_valid_d = 1'b1;
          wr_slot_d  = fsl;
          wr_data_d  = {1'b1, a_value_q, a_key_q};
        end else begin
          ins_fail = 1'b1;
        end
      end
      OP_DELETE: begin
        wr_valid_d = any_match;
        wr_slot_d  = msl;
      end
      default: ;
    endcase
    hit_cnt_d      = (res_hit_d && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
    ins_fail_cnt_d = (ins_fail && ins_fail_cnt_q != 16'hFFFF) ? ins_fail_cnt_q + 16'd1 : ins_fail_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_opt_q        <= OP_IDLE;
      res_valid_q    <= 1'b0;
      res_hit_q      <= 1'b0;
      res_opt_q      <= '0;
      wr_valid_q     <= 1'b0;
      wr_index_q     <= '0;
      wr_slot_q      <= '0;
      wr_data_q      <= '0;
      hit_cnt_q      <= '0;
      ins_fail_cnt_q <= '0;
    end else begin
      a_opt_q        <= op_e'(rd_opt_in);
      res_valid_q    <= res_valid_d;
      res_hit_q      <= res_hit_d;
      res_opt_q      <= res_opt_d;
      wr_valid_q     <= wr_valid_d;
      wr_index_q     <= wr_index_d;
      wr_slot_q      <= wr_slot_d;
      wr_data_q      <= wr_data_d;
      hit_cnt_q      <= hit_cnt_d;
      ins_fail_cnt_q <= ins_fail_cnt_d;
    end
  end

  // payload only; qualified by the reset opt/valid flops above
  always_ff @(posedge clk) begin
    a_match_q   <= match_d;
    a_free_q    <= free_d;
    a_vals_q    <= vals_d;
    a_key_q     <= rd_key_in;
    a_index_q   <= rd_index_in;
    a_value_q   <= rd_value_in;
    res_key_q   <= res_key_d;
    res_value_q <= res_value_d;
    res_slot_q  <= res_slot_d;
  end

  assign res_valid    = res_valid_q;
  assign res_opt      = res_opt_q;
  assign res_key      = res_key_q;
  assign res_hit      = res_hit_q;
  assign res_value    = res_value_q;
  assign res_slot     = res_slot_q;
  assign wr_valid     = wr_valid_q;
  assign wr_index     = wr_index_q;
  assign wr_slot      = wr_slot_q;
  assign wr_data      = wr_data_q;
  assign hit_cnt      = hit_cnt_q;
  assign ins_fail_cnt = ins_fail_cnt_q;

endmodule

// File: tb/tb_hash_match_stage.sv
// Directed bench for hash_match_stage: row-level reference model plus a
// per-cycle compare and literal spot checks.
`timescale 1ns/1ps
module tb_hash_match_stage;
  localparam int NM = 4, NW = 8, IW = 12, DW = 64, KW = 32, VW = 31;

  typedef logic [NM-1:0][DW-1:0] row_t;
  typedef struct {
    bit rv; bit hit; logic [1:0] slot; logic [VW-1:0] val; logic [1:0] opt; logic [KW-1:0] key;
    bit wv; logic [IW-1:0] widx; logic [1:0] wslot; logic [DW-1:0] wdata; logic [15:0] hc; logic [15:0] fc;
  } exp_t;
  typedef struct { bit v; logic [IW-1:0] idx; logic [1:0] slot; logic [DW-1:0] data; } wr_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [NM*NW*DW-1:0] rd_out_all_update = '0;
  logic [KW-1:0] rd_key_in = '0;
  logic [1:0]    rd_opt_in = '0;
  logic [IW-1:0] rd_index_in = '0;
  logic [VW-1:0] rd_value_in = '0;
  logic res_valid, res_hit, wr_valid;
  logic [1:0] res_opt, res_slot, wr_slot;
  logic [KW-1:0] res_key;
  logic [VW-1:0] res_value;
  logic [IW-1:0] wr_index;
  logic [DW-1:0] wr_data;
  logic [15:0] hit_cnt, ins_fail_cnt;

  hash_match_stage #(.NUM_MUL(NM), .NUM_WR(NW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .KEY_WIDTH(KW)) dut (
    .clk(clk), .reset(rst_n), .rd_out_all_update(rd_out_all_update), .rd_key_in(rd_key_in),
    .rd_opt_in(rd_opt_in), .rd_index_in(rd_index_in), .rd_value_in(rd_value_in),
    .res_valid(res_valid), .res_opt(res_opt), .res_key(res_key), .res_hit(res_hit),
    .res_value(res_value), .res_slot(res_slot), .wr_valid(wr_valid), .wr_index(wr_index),
    .wr_slot(wr_slot), .wr_data(wr_data), .hit_cnt(hit_cnt), .ins_fail_cnt(ins_fail_cnt));

  always #5 clk = ~clk;

  int cyc = 0, n_chk = 0, n_err = 0, hc = 0, fc = 0;
  bit run_chk = 0;
  exp_t exp_q [int];
  wr_t  hist [$];
  exp_t cx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ent(input logic [VW-1:0] v, input logic [KW-1:0] k);
    return {1'b1, v, k};
  endfunction

  // Drive one op for one cycle and predict what emerges two cycles later.
  task automatic do_op(input logic [1:0] opt, input logic [KW-1:0] key, input logic [IW-1:0] idx,
                       input logic [VW-1:0] val, input row_t r, input bit spread);
    logic [NM*NW*DW-1:0] flat;
    logic [DW-1:0] acc, mask;
    row_t e;
    int ms, fs;
    bit hit, hasf;
    wr_t w;
    exp_t x;
    for (int m = 0; m < NM; m++) begin
      acc = r[m];
      for (int b = 1; b < NW; b++) begin
        mask = spread ? {$urandom, $urandom} : '0;
        flat[(b*NM+m)*DW +: DW] = mask;
        acc = acc ^ mask;
      end
      flat[m*DW +: DW] = acc;
    end
    rd_out_all_update = flat; rd_opt_in = opt; rd_key_in = key; rd_index_in = idx; rd_value_in = val;
    // row as the op should see it: memory plus the two most recent unretired writes
    e = r;
    foreach (hist[i]) if (hist[i].v && hist[i].idx == idx) e[hist[i].slot] = hist[i].data;
    hit = 0; hasf = 0; ms = 0; fs = 0;
    for (int m = 0; m < NM; m++) begin
      if (!hit && e[m][DW-1] && e[m][KW-1:0] == key) begin hit = 1; ms = m; end
      if (!hasf && !e[m][DW-1]) begin hasf = 1; fs = m; end
    end
    w.v = 0; w.idx = idx; w.slot = 2'd0; w.data = '0;
    if (opt == 2'd2) begin
      if (hit)       begin w.v = 1; w.slot = 2'(ms); w.data = {1'b1, val, key}; end
      else if (hasf) begin w.v = 1; w.slot = 2'(fs); w.data = {1'b1, val, key}; end
      else if (fc < 65535) fc++;
    end else if (opt == 2'd3 && hit) begin
      w.v = 1; w.slot = 2'(ms); w.data = '0;
    end
    x.rv = (opt != 2'd0); x.opt = opt; x.key = key; x.hit = x.rv && hit;
    x.val = hit ? e[ms][DW-2:KW] : '0; x.slot = 2'(ms);
    if (x.hit && hc < 65535) hc++;
    x.wv = w.v; x.widx = idx; x.wslot = w.slot; x.wdata = w.data;
    x.hc = 16'(hc); x.fc = 16'(fc);
    exp_q[cyc + 2] = x;
    hist.push_back(w);
    if (hist.size() > 2) void'(hist.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic idle();
    do_op(2'd0, '0, '0, '0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (run_chk && rst_n) begin
      if (exp_q.exists(cyc)) begin
        cx = exp_q[cyc];
        exp_q.delete(cyc);
        chk("res_valid", res_valid, cx.rv);
        chk("wr_valid", wr_valid, cx.wv);
        chk("hit_cnt", hit_cnt, cx.hc);
        chk("ins_fail_cnt", ins_fail_cnt, cx.fc);
        if (cx.rv) begin
          chk("res_opt", res_opt, cx.opt);
          chk("res_key", res_key, cx.key);
          chk("res_hit", res_hit, cx.hit);
          chk("res_value", res_value, cx.val);
          if (cx.hit) chk("res_slot", res_slot, cx.slot);
        end
        if (cx.wv) begin
          chk("wr_index", wr_index, cx.widx);
          chk("wr_slot", wr_slot, cx.wslot);
          chk("wr_data", wr_data, cx.wdata);
        end
      end else begin
        chk("quiet_res_valid", res_valid, 0);
        chk("quiet_wr_valid", wr_valid, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r, full;
    full = '0;
    for (int m = 0; m < NM; m++) full[m] = ent(31'(m + 1), 32'(m + 1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_res_hit", res_hit, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_ins_fail_cnt", ins_fail_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; run_chk = 1;
    @(posedge clk); #1;

    // search hit, entry wholly in bank 0
    r = '0; r[2] = ent(31'd7, 32'h1234);
    do_op(2'd1, 32'h1234, 12'h010, '0, r, 0); idle();
    chk("s_hit", res_hit, 1); chk("s_slot", res_slot, 2); chk("s_value", res_value, 7);
    chk("s_wr_valid", wr_valid, 0); chk("s_hit_cnt", hit_cnt, 1);

    // search miss, banks spread
    do_op(2'd1, 32'h999, 12'h010, '0, r, 1); idle();
    chk("miss_hit", res_hit, 0); chk("miss_value", res_value, 0);

    // insert into first free slot
    r = '0; r[0] = ent(31'd1, 32'd1); r[1] = ent(31'd2, 32'd2);
    do_op(2'd2, 32'hAB, 12'h020, 31'd5, r, 1); idle();
    chk("ins_wr_valid", wr_valid, 1); chk("ins_wr_slot", wr_slot, 2);
    chk("ins_wr_data", wr_data, 64'h8000_0005_0000_00AB); chk("ins_hit", res_hit, 0);
    chk("ins_wr_index", wr_index, 12'h020);

    // insert over an existing key
    r = '0; r[0] = ent(31'd3, 32'h70); r[3] = ent(31'd1, 32'h77);
    do_op(2'd2, 32'h77, 12'h030, 31'h22, r, 1); idle();
    chk("upd_slot", wr_slot, 3); chk("upd_data", wr_data, 64'h8000_0022_0000_0077);
    chk("upd_hit", res_hit, 1);

    // delete with duplicates, then delete miss
    r = '0; r[1] = ent(31'd4, 32'h55); r[3] = ent(31'd8, 32'h55);
    do_op(2'd3, 32'h55, 12'h040, '0, r, 1); idle();
    chk("del_wr_valid", wr_valid, 1); chk("del_slot", wr_slot, 1);
    chk("del_data", wr_data, 0); chk("del_hit", res_hit, 1);
    do_op(2'd3, 32'h66, 12'h040, '0, r, 1); idle();
    chk("delmiss_wr_valid", wr_valid, 0); chk("delmiss_hit", res_hit, 0);

    // back-to-back insert then search on a row memory still shows empty
    do_op(2'd2, 32'h10, 12'h050, 31'd9, '0, 0);
    do_op(2'd1, 32'h10, 12'h050, '0, '0, 0); idle();
    chk("fwd1_hit", res_hit, 1); chk("fwd1_slot", res_slot, 0); chk("fwd1_value", res_value, 9);

    // one-op gap, and a neighbouring index that must not forward
    do_op(2'd2, 32'h11, 12'h060, 31'd3, '0, 0);
    do_op(2'd1, 32'h11, 12'h061, '0, '0, 0);
    do_op(2'd1, 32'h11, 12'h060, '0, '0, 0); idle();
    chk("fwd2_hit", res_hit, 1); chk("fwd2_value", res_value, 3);

    // full row, no match
    do_op(2'd2, 32'h99, 12'h070, 31'd1, full, 1); idle();
    chk("full_wr_valid", wr_valid, 0); chk("full_fail_cnt", ins_fail_cnt, 1);

    // reset with an insert sitting in stage A
    do_op(2'd2, 32'hCC, 12'h080, 31'd1, '0, 0);
    rd_opt_in = 2'd0; rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0); chk("mid_rst_wr_valid", wr_valid, 0);
    chk("mid_rst_hit_cnt", hit_cnt, 0); chk("mid_rst_fail_cnt", ins_fail_cnt, 0);
    exp_q.delete(); hist.delete(); hc = 0; fc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(); idle();
    chk("post_rst_wr_valid", wr_valid, 0);
    r = '0; r[2] = ent(31'd7, 32'h1234);
    do_op(2'd1, 32'h1234, 12'h010, '0, r, 1); idle();
    chk("post_rst_hit_cnt", hit_cnt, 1);

    // fail counter saturation
    repeat (65536) do_op(2'd2, 32'h99, 12'h090, 31'd1, full, 0);
    idle(); idle();
    chk("sat_fail_cnt", ins_fail_cnt, 16'hFFFF);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
